// File: rtl/angle_tick_gen_if.sv
// angle_tick_gen_if: control and status bundle for the angle tick generator
interface angle_tick_gen_if #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8
);
  logic              ena;
  logic              start;
  logic              stop;
  logic [WIDTH-1:0]  period;
  logic [CWIDTH-1:0] count;
  logic              tick;
  logic              busy;
  logic              done;
  logic [CWIDTH-1:0] ticks_left;
  modport master (
    output ena, start, stop, period, count,
    input  tick, busy, done, ticks_left
  );
  modport slave (
    input  ena, start, stop, period, count,
    output tick, busy, done, ticks_left
  );
endinterface

// File: rtl/angle_tick_gen.sv
// angle_tick_gen: emits a burst of count ticks spaced period enabled clocks apart
module angle_tick_gen #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8
) (
  input logic               clk,
  input logic               srst,
  angle_tick_gen_if.slave   bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d, per_q, per_d;
  logic [CWIDTH-1:0] left_q, left_d;
  logic              tick_q, tick_d, done_q, done_d;
  // next state: stop beats start, start retriggers, otherwise count down and tick at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    left_d  = left_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (bus.ena) begin
      if (bus.stop) begin
        if (state_q == RUN) begin
          state_d = IDLE;
          left_d  = '0;
        end
      end else if (bus.start) begin
        per_d   = (bus.period == '0) ? WIDTH'(1) : bus.period;
        cnt_d   = per_d - WIDTH'(1);
        left_d  = bus.count;
        state_d = (bus.count != '0) ? RUN : IDLE;
        done_d  = (bus.count == '0) && (state_q == IDLE);
      end else if (state_q == RUN) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          tick_d  = 1'b1;
          left_d  = left_q - CWIDTH'(1);
          cnt_d   = per_q - WIDTH'(1);
          done_d  = (left_q == CWIDTH'(1));
          state_d = (left_q == CWIDTH'(1)) ? IDLE : RUN;
        end
      end
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      left_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      left_q  <= left_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end
  assign bus.tick       = tick_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.ticks_left = left_q;
endmodule

// File: tb/tb_angle_tick_gen.sv
// tb_angle_tick_gen: directed and random bursts checked against a tick-schedule model
module tb_angle_tick_gen;
  logic clk = 1'b0;
  logic srst;
  int total = 0;
  int bad = 0;
  int unsigned en_n = 0;
  int unsigned next_t = 0;
  int unsigned m_p = 1;
  int m_left = 0;
  bit m_run = 0;
  bit m_tick = 0;
  bit m_done = 0;
  angle_tick_gen_if #(.WIDTH(8), .CWIDTH(8)) bus ();
  angle_tick_gen #(.WIDTH(8), .CWIDTH(8)) dut (.clk(clk), .srst(srst), .bus(bus));
  always #5 clk = ~clk;

  // Model: ticks are scheduled at absolute enabled-edge numbers start+P, start+2P, ...
  task automatic model_edge();
    m_tick = 0;
    m_done = 0;
    if (srst) begin
      m_run = 0;
      m_left = 0;
    end else if (bus.ena) begin
      en_n++;
      if (bus.stop) begin
        if (m_run) begin
          m_run = 0;
          m_left = 0;
        end
      end else if (bus.start) begin
        m_p = (bus.period == 0) ? 1 : int'(bus.period);
        next_t = en_n + m_p;
        m_left = int'(bus.count);
        m_done = (bus.count == 0) && !m_run;
        m_run = (bus.count != 0);
      end else if (m_run && en_n == next_t) begin
        m_tick = 1;
        m_left--;
        next_t += m_p;
        if (m_left == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    total++;
    assert (bus.tick === m_tick) else begin
      bad++;
      $error("FAIL %s tick obs=%0b exp=%0b t=%0t", tag, bus.tick, m_tick, $time);
    end
    total++;
    assert (bus.done === m_done) else begin
      bad++;
      $error("FAIL %s done obs=%0b exp=%0b t=%0t", tag, bus.done, m_done, $time);
    end
    total++;
    assert (bus.busy === m_run) else begin
      bad++;
      $error("FAIL %s busy obs=%0b exp=%0b t=%0t", tag, bus.busy, m_run, $time);
    end
    total++;
    assert (bus.ticks_left === 8'(m_left)) else begin
      bad++;
      $error("FAIL %s ticks_left obs=%0d exp=%0d t=%0t", tag, bus.ticks_left, m_left, $time);
    end
  endtask

  task automatic drive(bit e, bit s, bit p, logic [7:0] per, logic [7:0] c, string tag);
    bus.ena = e;
    bus.start = s;
    bus.stop = p;
    bus.period = per;
    bus.count = c;
    step(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 8'd0, 8'd0, tag);
  endtask

  initial begin
    srst = 1;
    bus.ena = 1;
    bus.start = 1;
    bus.stop = 0;
    bus.period = 8'd3;
    bus.count = 8'd3;
    step("reset");
    step("reset");
    srst = 0;
    idle(2, "post_reset");
    drive(1, 1, 0, 8'd4, 8'd3, "basic_start");
    idle(14, "basic");
    drive(1, 1, 0, 8'd0, 8'd5, "minper_start");
    idle(7, "minper");
    drive(1, 1, 0, 8'd7, 8'd0, "zero_count");
    idle(4, "zero_count_after");
    drive(1, 1, 0, 8'd3, 8'd4, "retrig_a");
    idle(2, "retrig_wait");
    drive(1, 1, 0, 8'd2, 8'd2, "retrig_b");
    idle(6, "retrig_run");
    drive(1, 1, 0, 8'd3, 8'd4, "stopstart_a");
    idle(2, "stopstart_wait");
    drive(1, 1, 1, 8'd2, 8'd2, "stopstart");
    idle(5, "stopstart_after");
    drive(1, 0, 1, 8'd2, 8'd2, "stop_idle");
    drive(1, 1, 0, 8'd4, 8'd2, "stall_start");
    idle(1, "stall_pre");
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 8'd9, 8'd9, "stall");
    idle(9, "stall_resume");
    drive(1, 1, 0, 8'd4, 8'd3, "rst_start");
    idle(5, "rst_pre");
    srst = 1;
    drive(1, 1, 0, 8'd4, 8'd3, "rst_mid");
    srst = 0;
    idle(14, "rst_after");
    drive(1, 1, 0, 8'd255, 8'd2, "maxper_start");
    idle(515, "maxper");
    drive(1, 1, 0, 8'd1, 8'd255, "maxcnt_start");
    idle(260, "maxcnt");
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] per, c;
      per = ($urandom_range(0, 40) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      c = m_run ? 8'($urandom_range(1, 5)) : 8'($urandom_range(0, 5));
      srst = ($urandom_range(0, 150) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, per, c, "random");
    end
    srst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
